// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with RMW ops, write masks, illegal-access detection, trap/MRET and vectored mtvec.
// Define CSR_INSTRET_EN to implement the instret counter at 0xC02/0xC82.
module csr_unit #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     CNT_WIDTH   = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_addr_i,
    input  logic [1:0]      csr_op_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_illegal_o,
    input  logic            retire_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic            mret_i,
    output logic [XLEN-1:0] trap_vector_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            irq_enable_o
);
    localparam logic [XLEN-1:0] MIE_MASK = XLEN'(12'h888);
    logic [CNT_WIDTH-1:0] cycle;
    logic [XLEN-1:0] mie_reg, mtvec, mscratch, mepc, mcause, mstatus, rdata, wval, base;
    logic status_mie, status_mpie, impl, wr_req, illegal, wr;
`ifdef CSR_INSTRET_EN
    logic [CNT_WIDTH-1:0] instret;
`else
    logic unused_retire;
    assign unused_retire = retire_i;
`endif
    // MPP is hardwired to machine mode
    assign mstatus = XLEN'({2'b11, 3'b000, status_mpie, 3'b000, status_mie, 3'b000});
    always_comb begin
        impl = 1'b1;
        rdata = '0;
        case (csr_addr_i)
            12'hC00: rdata = XLEN'(cycle);
            12'hC80: begin
                impl = (XLEN == 32);
                rdata = impl ? XLEN'(cycle >> 32) : '0;
            end
`ifdef CSR_INSTRET_EN
            12'hC02: rdata = XLEN'(instret);
            12'hC82: begin
                impl = (XLEN == 32);
                rdata = impl ? XLEN'(instret >> 32) : '0;
            end
`endif
            12'h300: rdata = mstatus;
            12'h304: rdata = mie_reg;
            12'h305: rdata = mtvec;
            12'h340: rdata = mscratch;
            12'h341: rdata = mepc;
            12'h342: rdata = mcause;
            default: impl = 1'b0;
        endcase
    end
    // RS/RC with a zero operand is a pure read and never trips the read-only check
    assign wr_req  = (csr_op_i == 2'b01) || (csr_op_i[1] && csr_wdata_i != '0);
    assign illegal = (csr_op_i != 2'b00) && (!impl || (wr_req && csr_addr_i[11:10] == 2'b11));
    assign wr      = wr_req && !illegal && !trap_i;
    assign wval    = csr_op_i == 2'b01 ? csr_wdata_i :
                     csr_op_i == 2'b10 ? rdata | csr_wdata_i : rdata & ~csr_wdata_i;
    assign base          = {mtvec[XLEN-1:2], 2'b00};
    assign trap_vector_o = mtvec[0] && trap_cause_i[XLEN-1] ? base + (trap_cause_i << 2) : base;
    assign csr_rdata_o   = rdata;
    assign csr_illegal_o = illegal;
    assign mepc_o        = mepc;
    assign irq_enable_o  = status_mie;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle       <= '0;
            status_mie  <= 1'b0;
            status_mpie <= 1'b0;
            mie_reg     <= '0;
            mtvec       <= MTVEC_RESET;
            mscratch    <= '0;
            mepc        <= '0;
            mcause      <= '0;
        end else begin
            cycle <= cycle + CNT_WIDTH'(1);
            if (trap_i) begin
                mepc        <= trap_pc_i & ~XLEN'(3);
                mcause      <= trap_cause_i;
                status_mpie <= status_mie;
                status_mie  <= 1'b0;
            end else begin
                if (mret_i) begin
                    status_mie  <= status_mpie;
                    status_mpie <= 1'b1;
                end else if (wr && csr_addr_i == 12'h300) begin
                    status_mie  <= wval[3];
                    status_mpie <= wval[7];
                end
                if (wr) begin
                    case (csr_addr_i)
                        12'h304: mie_reg  <= wval & MIE_MASK;
                        12'h305: mtvec    <= wval & ~XLEN'(2);
                        12'h340: mscratch <= wval;
                        12'h341: mepc     <= wval & ~XLEN'(3);
                        12'h342: mcause   <= wval;
                        default: ;
                    endcase
                end
            end
        end
    end
`ifdef CSR_INSTRET_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) instret <= '0;
        else if (retire_i) instret <= instret + CNT_WIDTH'(1);
    end
`endif
endmodule
